// File: rtl/alu_issue_stage_if.sv
// Bundle between the decode/issue stage and its neighbours: upstream instruction
// handshake plus the registered ID/EX slot that feeds the ALU. The slave side is the stage.
interface alu_issue_stage_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_alu_control;
  logic [XLEN-1:0] out_operand_a;
  logic [XLEN-1:0] out_operand_b;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rd;
  logic            out_writes_rd;
  logic            out_illegal;

  modport slave (
    input  flush, in_valid, in_inst, in_pc, in_rs1_data, in_rs2_data, out_ready,
    output in_ready, out_valid, out_alu_control, out_operand_a, out_operand_b,
           out_pc, out_rd, out_writes_rd, out_illegal
  );

  modport master (
    output flush, in_valid, in_inst, in_pc, in_rs1_data, in_rs2_data, out_ready,
    input  in_ready, out_valid, out_alu_control, out_operand_a, out_operand_b,
           out_pc, out_rd, out_writes_rd, out_illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: decodes the ALU op, selects operands/immediates and
// holds them in a single registered ID/EX slot behind a valid/ready handshake.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input logic              clk,
  input logic              rst,
  alu_issue_stage_if.slave bus
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0010,
    ALU_SLT  = 4'b0011,
    ALU_SLTU = 4'b0100,
    ALU_XOR  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_OR   = 4'b1000,
    ALU_AND  = 4'b1001
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd_idx;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, shamt;

  assign opcode = bus.in_inst[6:0];
  assign funct3 = bus.in_inst[14:12];
  assign funct7 = bus.in_inst[31:25];
  assign rd_idx = bus.in_inst[11:7];
  assign imm_i  = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
  assign imm_s  = {{20{bus.in_inst[31]}}, bus.in_inst[31:25], bus.in_inst[11:7]};
  assign imm_u  = {bus.in_inst[31:12], 12'b0};
  assign shamt  = {27'b0, bus.in_inst[24:20]};

  function automatic alu_op_e f3_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  alu_op_e         dec_ctrl;
  logic [XLEN-1:0] dec_a, dec_b;
  logic            dec_writes, dec_illegal;

  always_comb begin
    dec_ctrl    = ALU_ADD;
    dec_a       = '0;
    dec_b       = '0;
    dec_writes  = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_a      = bus.in_rs1_data;
        dec_b      = bus.in_rs2_data;
        dec_writes = 1'b1;
        dec_ctrl   = f3_op(funct3);
        if (funct7 == 7'h20 && funct3 == 3'b000)      dec_ctrl = ALU_SUB;
        else if (funct7 == 7'h20 && funct3 == 3'b101) dec_ctrl = ALU_SRA;
        else if (funct7 != 7'h00)                     dec_illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_a      = bus.in_rs1_data;
        dec_b      = imm_i;
        dec_writes = 1'b1;
        dec_ctrl   = f3_op(funct3);
        if (funct3 == 3'b001) begin
          dec_b = shamt;
          if (funct7 != 7'h00) dec_illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          dec_b = shamt;
          if (funct7 == 7'h20)      dec_ctrl = ALU_SRA;
          else if (funct7 != 7'h00) dec_illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        dec_b      = imm_u;
        dec_writes = 1'b1;
      end
      OPC_AUIPC: begin
        dec_a      = bus.in_pc;
        dec_b      = imm_u;
        dec_writes = 1'b1;
      end
      OPC_LOAD: begin
        dec_a       = bus.in_rs1_data;
        dec_b       = imm_i;
        dec_writes  = 1'b1;
        dec_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        dec_a       = bus.in_rs1_data;
        dec_b       = imm_s;
        dec_illegal = funct3[2] || (funct3 == 3'b011);
      end
      OPC_BRANCH: begin
        dec_a = bus.in_rs1_data;
        dec_b = bus.in_rs2_data;
        case (funct3[2:1])
          2'b00:   dec_ctrl = ALU_SUB;
          2'b10:   dec_ctrl = ALU_SLT;
          2'b11:   dec_ctrl = ALU_SLTU;
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        // Link value pc+4 is computed by the ALU itself.
        dec_a       = bus.in_pc;
        dec_b       = 32'd4;
        dec_writes  = 1'b1;
        dec_illegal = (opcode == OPC_JALR) && (funct3 != 3'b000);
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_ctrl   = ALU_ADD;
      dec_a      = '0;
      dec_b      = '0;
      dec_writes = 1'b0;
    end
    if (rd_idx == 5'd0) dec_writes = 1'b0;
  end

  logic            valid_q, valid_d;
  alu_op_e         ctrl_q, ctrl_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, pc_q, pc_d;
  logic [4:0]      rd_q, rd_d;
  logic            writes_rd_q, writes_rd_d;
  logic            illegal_q, illegal_d;
  logic            in_ready, load;

  assign in_ready     = (!valid_q || bus.out_ready) && !bus.flush;
  assign load         = bus.in_valid && in_ready;
  assign bus.in_ready = in_ready;

  always_comb begin
    valid_d     = valid_q;
    ctrl_d      = ctrl_q;
    a_d         = a_q;
    b_d         = b_q;
    pc_d        = pc_q;
    rd_d        = rd_q;
    writes_rd_d = writes_rd_q;
    illegal_d   = illegal_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d     = 1'b1;
      ctrl_d      = dec_ctrl;
      a_d         = dec_a;
      b_d         = dec_b;
      pc_d        = bus.in_pc;
      rd_d        = rd_idx;
      writes_rd_d = dec_writes;
      illegal_d   = dec_illegal;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      ctrl_q      <= ALU_ADD;
      a_q         <= '0;
      b_q         <= '0;
      pc_q        <= '0;
      rd_q        <= '0;
      writes_rd_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      a_q         <= a_d;
      b_q         <= b_d;
      pc_q        <= pc_d;
      rd_q        <= rd_d;
      writes_rd_q <= writes_rd_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.out_valid       = valid_q;
  assign bus.out_alu_control = ctrl_q;
  assign bus.out_operand_a   = a_q;
  assign bus.out_operand_b   = b_q;
  assign bus.out_pc          = pc_q;
  assign bus.out_rd          = rd_q;
  assign bus.out_writes_rd   = writes_rd_q;
  assign bus.out_illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed RV32I vectors with hand-computed
// expectations, plus stream, stall, flush and mid-stall reset scenarios.
module tb_alu_issue_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_stage_if #(.XLEN(32)) bus ();
  alu_issue_stage #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        writes_rd;
    logic        illegal;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] pc, input logic [4:0] rd, input logic w, input logic ill);
    exp_t e;
    e.ctrl = ctrl; e.a = a; e.b = b; e.pc = pc; e.rd = rd; e.writes_rd = w; e.illegal = ill;
    return e;
  endfunction

  // Monitor: every consumed slot is compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_output", 32'(bus.out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("out_ctrl",    32'(bus.out_alu_control), 32'(e.ctrl));
          checkOutput("out_a",       bus.out_operand_a,        e.a);
          checkOutput("out_b",       bus.out_operand_b,        e.b);
          checkOutput("out_pc",      bus.out_pc,               e.pc);
          checkOutput("out_rd",      32'(bus.out_rd),          32'(e.rd));
          checkOutput("out_writes",  32'(bus.out_writes_rd),   32'(e.writes_rd));
          checkOutput("out_illegal", 32'(bus.out_illegal),     32'(e.illegal));
        end
      end
    end
  end

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    bus.in_valid    = 1'b1;
    bus.in_inst     = inst;
    bus.in_pc       = pc;
    bus.in_rs1_data = rs1;
    bus.in_rs2_data = rs2;
  endtask

  task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] pc,
                               input logic [31:0] rs1, input logic [31:0] rs2, input exp_t e);
    int accepted;
    accepted = 0;
    drive(inst, pc, rs1, rs2);
    for (int i = 0; i < 10 && accepted == 0; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(e);
        accepted = 1;
      end
      @(posedge clk); #1;
    end
    checkOutput("accept", 32'(accepted), 32'd1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  logic [31:0] s_inst [4];
  logic [3:0]  s_ctrl [4];

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0;
    bus.in_rs1_data = '0; bus.in_rs2_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    checkOutput("rst_valid",    32'(bus.out_valid),       32'd0);
    checkOutput("rst_ctrl",     32'(bus.out_alu_control), 32'd0);
    checkOutput("rst_a",        bus.out_operand_a,        32'd0);
    checkOutput("rst_b",        bus.out_operand_b,        32'd0);
    checkOutput("rst_pc",       bus.out_pc,               32'd0);
    checkOutput("rst_rd",       32'(bus.out_rd),          32'd0);
    checkOutput("rst_writes",   32'(bus.out_writes_rd),   32'd0);
    checkOutput("rst_illegal",  32'(bus.out_illegal),     32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready),        32'd1);
    @(posedge clk); #1;

    // Single ADD: one-cycle latency, then slot empties.
    applyStimulus(32'h002081B3, 32'h100, 32'd5, 32'd7, mk(4'b0000, 32'd5, 32'd7, 32'h100, 5'd3, 1'b1, 1'b0));
    idle();
    @(negedge clk);
    checkOutput("latency_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    checkOutput("consumed_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;

    // Directed decode vectors, issued back to back.
    applyStimulus(32'h40208133, 32'h104, 32'h10, 32'h3, mk(4'b0001, 32'h10, 32'h3, 32'h104, 5'd2, 1'b1, 1'b0));
    applyStimulus(32'h40335293, 32'h108, 32'hF0000000, 32'hDEAD, mk(4'b0111, 32'hF0000000, 32'd3, 32'h108, 5'd5, 1'b1, 1'b0));
    applyStimulus(32'hFFF00093, 32'h10C, 32'h0, 32'h33, mk(4'b0000, 32'h0, 32'hFFFFFFFF, 32'h10C, 5'd1, 1'b1, 1'b0));
    applyStimulus(32'h123450B7, 32'h110, 32'h99, 32'h77, mk(4'b0000, 32'h0, 32'h12345000, 32'h110, 5'd1, 1'b1, 1'b0));
    applyStimulus(32'hABCDE297, 32'h114, 32'h99, 32'h77, mk(4'b0000, 32'h114, 32'hABCDE000, 32'h114, 5'd5, 1'b1, 1'b0));
    applyStimulus(32'hFFC12383, 32'h118, 32'h1000, 32'h77, mk(4'b0000, 32'h1000, 32'hFFFFFFFC, 32'h118, 5'd7, 1'b1, 1'b0));
    applyStimulus(32'hFE20A823, 32'h11C, 32'h2000, 32'h55, mk(4'b0000, 32'h2000, 32'hFFFFFFF0, 32'h11C, 5'd16, 1'b0, 1'b0));
    applyStimulus(32'h0020E063, 32'h120, 32'd3, 32'd9, mk(4'b0100, 32'd3, 32'd9, 32'h120, 5'd0, 1'b0, 1'b0));
    applyStimulus(32'h00208063, 32'h124, 32'd4, 32'd4, mk(4'b0001, 32'd4, 32'd4, 32'h124, 5'd0, 1'b0, 1'b0));
    applyStimulus(32'h0020C063, 32'h128, 32'd1, 32'd2, mk(4'b0011, 32'd1, 32'd2, 32'h128, 5'd0, 1'b0, 1'b0));
    applyStimulus(32'h0020A063, 32'h12C, 32'd1, 32'd2, mk(4'b0000, 32'd0, 32'd0, 32'h12C, 5'd0, 1'b0, 1'b1));
    applyStimulus(32'h02208133, 32'h130, 32'd6, 32'd7, mk(4'b0000, 32'd0, 32'd0, 32'h130, 5'd2, 1'b0, 1'b1));
    applyStimulus(32'h000000EF, 32'h140, 32'd6, 32'd7, mk(4'b0000, 32'h140, 32'd4, 32'h140, 5'd1, 1'b1, 1'b0));
    applyStimulus(32'h00008067, 32'h144, 32'd6, 32'd7, mk(4'b0000, 32'h144, 32'd4, 32'h144, 5'd0, 1'b0, 1'b0));
    applyStimulus(32'h00009067, 32'h148, 32'd6, 32'd7, mk(4'b0000, 32'd0, 32'd0, 32'h148, 5'd0, 1'b0, 1'b1));
    applyStimulus(32'h40131093, 32'h14C, 32'd6, 32'd7, mk(4'b0000, 32'd0, 32'd0, 32'h14C, 5'd1, 1'b0, 1'b1));
    applyStimulus(32'h0000007F, 32'h150, 32'd6, 32'd7, mk(4'b0000, 32'd0, 32'd0, 32'h150, 5'd0, 1'b0, 1'b1));
    applyStimulus(32'h00208033, 32'h154, 32'd8, 32'd9, mk(4'b0000, 32'd8, 32'd9, 32'h154, 5'd0, 1'b0, 1'b0));
    applyStimulus(32'h4020D1B3, 32'h158, 32'h80000000, 32'd4, mk(4'b0111, 32'h80000000, 32'd4, 32'h158, 5'd3, 1'b1, 1'b0));
    applyStimulus(32'h00013183, 32'h15C, 32'd8, 32'd9, mk(4'b0000, 32'd0, 32'd0, 32'h15C, 5'd3, 1'b0, 1'b1));
    idle();
    drain();

    // Full-throughput stream of four R-type ops.
    s_inst = '{32'h0020C1B3, 32'h0020E1B3, 32'h0020F1B3, 32'h002091B3};
    s_ctrl = '{4'b0101, 4'b1000, 4'b1001, 4'b0010};
    for (int i = 0; i < 4; i++) begin
      drive(s_inst[i], 32'h2000 + 32'(4 * i), 32'h100 + 32'(i), 32'h200 + 32'(i));
      @(negedge clk);
      checkOutput("stream_in_ready", 32'(bus.in_ready), 32'd1);
      if (i > 0) checkOutput("stream_out_valid", 32'(bus.out_valid), 32'd1);
      exp_q.push_back(mk(s_ctrl[i], 32'h100 + 32'(i), 32'h200 + 32'(i), 32'h2000 + 32'(4 * i), 5'd3, 1'b1, 1'b0));
      @(posedge clk); #1;
    end
    idle();
    @(negedge clk);
    checkOutput("stream_last_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    drain();

    // Stall: slot holds SLT while a waiting SRL is refused, then both move in one edge.
    applyStimulus(32'h0020A1B3, 32'h3000, 32'hAAAA0000, 32'h5555, mk(4'b0011, 32'hAAAA0000, 32'h5555, 32'h3000, 5'd3, 1'b1, 1'b0));
    bus.out_ready = 1'b0;
    drive(32'h0020D1B3, 32'h3004, 32'h80000000, 32'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", 32'(bus.in_ready),        32'd0);
      checkOutput("stall_valid",    32'(bus.out_valid),       32'd1);
      checkOutput("stall_ctrl",     32'(bus.out_alu_control), 32'd3);
      checkOutput("stall_a",        bus.out_operand_a,        32'hAAAA0000);
      checkOutput("stall_b",        bus.out_operand_b,        32'h5555);
      checkOutput("stall_pc",       bus.out_pc,               32'h3000);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.push_back(mk(4'b0110, 32'h80000000, 32'd4, 32'h3004, 5'd3, 1'b1, 1'b0));
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    checkOutput("release_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    drain();

    // Flush with a held slot and a pending input: both are dropped.
    applyStimulus(32'h0020B1B3, 32'h4000, 32'd1, 32'd2, mk(4'b0100, 32'd1, 32'd2, 32'h4000, 5'd3, 1'b1, 1'b0));
    bus.out_ready = 1'b0;
    bus.flush     = 1'b1;
    drive(32'h002081B3, 32'h4004, 32'd3, 32'd4);
    @(negedge clk);
    checkOutput("flush_in_ready", 32'(bus.in_ready),  32'd0);
    checkOutput("flush_valid_pre", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    idle();
    checkOutput("flush_queue", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("flush_valid_post", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Reset during a stall clears the slot and every output.
    applyStimulus(32'hFFF00093, 32'h5000, 32'h0, 32'h0, mk(4'b0000, 32'h0, 32'hFFFFFFFF, 32'h5000, 5'd1, 1'b1, 1'b0));
    bus.out_ready = 1'b0;
    idle();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst_queue", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    @(negedge clk);
    checkOutput("midrst_valid",   32'(bus.out_valid),       32'd0);
    checkOutput("midrst_ctrl",    32'(bus.out_alu_control), 32'd0);
    checkOutput("midrst_a",       bus.out_operand_a,        32'd0);
    checkOutput("midrst_b",       bus.out_operand_b,        32'd0);
    checkOutput("midrst_pc",      bus.out_pc,               32'd0);
    checkOutput("midrst_rd",      32'(bus.out_rd),          32'd0);
    checkOutput("midrst_writes",  32'(bus.out_writes_rd),   32'd0);
    checkOutput("midrst_illegal", 32'(bus.out_illegal),     32'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
